// File: rtl/for_seq_ctrl.sv
// -----------------------------------------------------------------------------
// for_seq_ctrl
//
// Sequencer for the accumulate-then-multiply-subtract datapath.
// One (A, B) operand pair is accepted per transaction. The persistent
// accumulator TEMP is then stepped by +1 once per cycle, COUNT times, and
// XOUT = (TEMP * A) - B (modulo 2^NBITS) is computed and held until the
// consumer takes it. Only one transaction is in flight at a time.
//
// Optional feature macro: FOR_SEQ_OVF_EN
//   When defined, the OVF output exists. It is registered together with XOUT
//   and flags either a product that does not fit in NBITS or a truncated
//   product smaller than B (i.e. the subtraction borrowed).
//
// Parameters
//   NBITS  width of A, B, TEMP and XOUT
//   COUNT  accumulator increments per transaction (1..255)
//   INIT   value loaded into TEMP on reset
//
// Ports
//   CLK        in   rising-edge clock
//   RST        in   asynchronous reset, active high
//   IN_VALID   in   operand pair valid
//   IN_READY   out  block can accept operands (combinational, IDLE only)
//   A          in   multiplicand, unsigned
//   B          in   subtrahend, unsigned
//   OUT_VALID  out  XOUT valid
//   OUT_READY  in   consumer accepts XOUT
//   XOUT       out  result, unsigned
//   TEMP       out  current accumulator value, registered
//   BUSY       out  high in any state other than IDLE
//   OVF        out  overflow flag (only with FOR_SEQ_OVF_EN)
// -----------------------------------------------------------------------------
module for_seq_ctrl #(
    parameter int NBITS = 8,
    parameter int COUNT = 4,
    parameter int INIT  = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [NBITS-1:0] A,
    input  logic [NBITS-1:0] B,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [NBITS-1:0] XOUT,
    output logic [NBITS-1:0] TEMP,
    output logic             BUSY
`ifdef FOR_SEQ_OVF_EN
    ,
    output logic             OVF
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    // The step counter runs 0..COUNT-1; the increment taken while it equals
    // LAST_STEP is the COUNT-th one, after which the datapath moves to CALC.
    localparam logic [7:0]       LAST_STEP = 8'(COUNT - 1);
    localparam logic [NBITS-1:0] TEMP_INIT = NBITS'(INIT);
    localparam logic [NBITS-1:0] TEMP_ONE  = NBITS'(1);

    state_t           state_reg,     state_next;
    logic [NBITS-1:0] temp_reg,      temp_next;
    logic [7:0]       cnt_reg,       cnt_next;
    logic [NBITS-1:0] a_reg,         a_next;
    logic [NBITS-1:0] b_reg,         b_next;
    logic [NBITS-1:0] xout_reg,      xout_next;
    logic             out_valid_reg, out_valid_next;

    // Truncated product: only the low NBITS feed the subtraction.
    logic [NBITS-1:0] prod_low;
    assign prod_low = temp_reg * a_reg;

`ifdef FOR_SEQ_OVF_EN
    logic             ovf_reg, ovf_next;
    logic [2*NBITS-1:0] prod_full;
    logic             ovf_calc;

    assign prod_full = {{NBITS{1'b0}}, temp_reg} * {{NBITS{1'b0}}, a_reg};
    // Overflow: product spills past NBITS, or the subtraction borrows.
    assign ovf_calc  = (prod_full[2*NBITS-1:NBITS] != '0) || (prod_low < b_reg);
`endif

    // ---------------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg     <= IDLE;
            temp_reg      <= TEMP_INIT;
            cnt_reg       <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            xout_reg      <= '0;
            out_valid_reg <= 1'b0;
`ifdef FOR_SEQ_OVF_EN
            ovf_reg       <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            temp_reg      <= temp_next;
            cnt_reg       <= cnt_next;
            a_reg         <= a_next;
            b_reg         <= b_next;
            xout_reg      <= xout_next;
            out_valid_reg <= out_valid_next;
`ifdef FOR_SEQ_OVF_EN
            ovf_reg       <= ovf_next;
`endif
        end
    end

    // ---------------------------------------------------------------------
    // Next-state and datapath logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        temp_next      = temp_reg;
        cnt_next       = cnt_reg;
        a_next         = a_reg;
        b_next         = b_reg;
        xout_next      = xout_reg;
        out_valid_next = out_valid_reg;
`ifdef FOR_SEQ_OVF_EN
        ovf_next       = ovf_reg;
`endif

        case (state_reg)
            IDLE: begin
                if (IN_VALID) begin
                    a_next     = A;
                    b_next     = B;
                    cnt_next   = '0;
                    state_next = STEP;
                end
            end

            STEP: begin
                // TEMP wraps silently at 2^NBITS and is never cleared here.
                temp_next = temp_reg + TEMP_ONE;
                cnt_next  = cnt_reg + 8'd1;
                if (cnt_reg == LAST_STEP) begin
                    state_next = CALC;
                end
            end

            CALC: begin
                xout_next      = prod_low - b_reg;
                out_valid_next = 1'b1;
`ifdef FOR_SEQ_OVF_EN
                ovf_next       = ovf_calc;
`endif
                state_next     = DONE;
            end

            DONE: begin
                // Result is held until taken; no bypass into a new accept.
                if (OUT_READY) begin
                    out_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign IN_READY  = (state_reg == IDLE);
    assign BUSY      = (state_reg != IDLE);
    assign OUT_VALID = out_valid_reg;
    assign XOUT      = xout_reg;
    assign TEMP      = temp_reg;
`ifdef FOR_SEQ_OVF_EN
    assign OVF       = ovf_reg;
`endif

endmodule

// File: tb/tb_for_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_for_seq_ctrl
//
// Scoreboard bench for for_seq_ctrl. The driver pushes the hand-computed
// expected result of every issued transaction into a queue; an independent
// monitor pops and compares whenever the DUT completes an output handshake.
// Latency, TEMP, handshake and reset behaviour are checked in the driver.
// OVF is connected and checked only when FOR_SEQ_OVF_EN is defined.
// -----------------------------------------------------------------------------
module tb_for_seq_ctrl;

    localparam int NBITS = 8;
    localparam int COUNT = 4;
    localparam int INIT  = 1;

    logic             CLK       = 1'b0;
    logic             RST       = 1'b1;
    logic             IN_VALID  = 1'b0;
    logic             OUT_READY = 1'b1;
    logic [NBITS-1:0] A         = '0;
    logic [NBITS-1:0] B         = '0;
    logic             IN_READY;
    logic             OUT_VALID;
    logic [NBITS-1:0] XOUT;
    logic [NBITS-1:0] TEMP;
    logic             BUSY;
`ifdef FOR_SEQ_OVF_EN
    logic             OVF;
`endif

    for_seq_ctrl #(
        .NBITS(NBITS),
        .COUNT(COUNT),
        .INIT (INIT)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .A        (A),
        .B        (B),
        .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY),
        .XOUT     (XOUT),
        .TEMP     (TEMP),
        .BUSY     (BUSY)
`ifdef FOR_SEQ_OVF_EN
        ,
        .OVF      (OVF)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [NBITS-1:0] x;
        logic             ovf;
        string            name;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Monitor: one pop per completed output handshake
    // ---------------------------------------------------------------------
    always @(negedge CLK) begin
        exp_t e;
        if (!RST && OUT_VALID && OUT_READY) begin
            if (q.size() == 0) begin
                check("unexpected_output_queue_size", q.size(), 1);
            end else begin
                e = q.pop_front();
                check({e.name, "_xout"}, XOUT, e.x);
`ifdef FOR_SEQ_OVF_EN
                check({e.name, "_ovf"}, OVF, e.ovf);
`endif
                $display("txn %s: XOUT=%0d expected=%0d TEMP=%0d", e.name, XOUT, e.x, TEMP);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Driver tasks
    // ---------------------------------------------------------------------
    // Issue one transaction and return with OUT_VALID first high.
    task automatic send(input string name, input logic [NBITS-1:0] a, input logic [NBITS-1:0] b,
                        input logic [NBITS-1:0] ex, input logic eo, input logic [NBITS-1:0] et);
        int   cnt;
        exp_t e;
        cnt = 0;
        while (!IN_READY && cnt < 50) begin
            @(posedge CLK); #1;
            cnt++;
        end
        check({name, "_in_ready"}, IN_READY, 1);
        A        = a;
        B        = b;
        IN_VALID = 1'b1;
        e.x      = ex;
        e.ovf    = eo;
        e.name   = name;
        q.push_back(e);
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        A        = ~a;  // operands are don't-care after the capture edge
        B        = ~b;
        check({name, "_busy"}, BUSY, 1);
        cnt = 0;
        do begin
            @(posedge CLK); #1;
            cnt++;
        end while (!OUT_VALID && cnt < 50);
        check({name, "_latency"}, cnt, COUNT + 1);
        check({name, "_temp"}, TEMP, et);
    endtask

    // Wait for the output handshake to complete; XOUT must then be held in IDLE.
    task automatic drain(input string name, input logic [NBITS-1:0] ex);
        int cnt;
        cnt = 0;
        while (OUT_VALID && cnt < 50) begin
            @(posedge CLK); #1;
            cnt++;
        end
        check({name, "_released"}, OUT_VALID, 0);
        check({name, "_xout_held_idle"}, XOUT, ex);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        @(posedge CLK); #1;
        q.delete();
        check("rst_temp", TEMP, INIT);
        check("rst_out_valid", OUT_VALID, 0);
        check("rst_xout", XOUT, 0);
        check("rst_in_ready", IN_READY, 1);
        check("rst_busy", BUSY, 0);
`ifdef FOR_SEQ_OVF_EN
        check("rst_ovf", OVF, 0);
`endif
        RST = 1'b0;
    endtask

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    initial begin
        do_reset();

        // TEMP 1 -> 5, 15 - 2 = 13
        send("t1", 8'd3, 8'd2, 8'd13, 1'b0, 8'd5);
        drain("t1", 8'd13);
        // TEMP persists: 5 -> 9, 27 - 2 = 25
        send("t2", 8'd3, 8'd2, 8'd25, 1'b0, 8'd9);
        drain("t2", 8'd25);

        // 5 * 200 = 1000 -> 232, product overflow
        do_reset();
        send("t3", 8'd200, 8'd0, 8'd232, 1'b1, 8'd5);
        drain("t3", 8'd232);

        // 0 - 1 -> 255, borrow; then B=0 gives no overflow
        do_reset();
        send("t4", 8'd0, 8'd1, 8'd255, 1'b1, 8'd5);
        drain("t4", 8'd255);
        send("t5", 8'd0, 8'd0, 8'd0, 1'b0, 8'd9);
        drain("t5", 8'd0);

        // Consumer stalls for 10 cycles while new operands are offered
        OUT_READY = 1'b0;
        send("hold", 8'd5, 8'd1, 8'd64, 1'b0, 8'd13);
        IN_VALID = 1'b1;
        A        = 8'd7;
        B        = 8'd7;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1;
            check("hold_out_valid", OUT_VALID, 1);
            check("hold_xout", XOUT, 64);
            check("hold_in_ready", IN_READY, 0);
            check("hold_temp", TEMP, 13);
        end
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        drain("hold", 8'd64);
        repeat (3) @(posedge CLK);
        #1;
        check("hold_idle_busy", BUSY, 0);
        check("hold_no_capture_temp", TEMP, 13);
        send("after_hold", 8'd2, 8'd0, 8'd34, 1'b0, 8'd17);
        drain("after_hold", 8'd34);

        // Abort mid-STEP after two increments: 17 -> 19, then reset
        A        = 8'd9;
        B        = 8'd9;
        IN_VALID = 1'b1;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check("abort_temp_before_rst", TEMP, 19);
        RST = 1'b1;
        #1;
        check("abort_temp_now", TEMP, INIT);
        check("abort_out_valid_now", OUT_VALID, 0);
        check("abort_busy_now", BUSY, 0);
        @(posedge CLK); #1;
        RST = 1'b0;
        send("post_abort", 8'd3, 8'd2, 8'd13, 1'b0, 8'd5);
        drain("post_abort", 8'd13);

        repeat (2) @(posedge CLK);
        check("scoreboard_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
